// File: rtl/mips_pkg.sv
// Shared MIPS definitions: reset vector, NOP encoding, primary opcodes and the
// fetch-stage state encoding, plus small PC helpers used by the front end.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetchState_t;

  function automatic logic [31:0] pcPlus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] wordAlign(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Flush beats hold; with neither hold nor load the
// register takes a bubble so decode never sees a stale instruction twice.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hold_i,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o,
  output logic [5:0]  opcode_o
);

  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc4_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0;
    end else if (!hold_i) begin
      if (load_i) begin
        valid_q <= 1'b1;
        instr_q <= instr_i;
        pc4_q   <= pc4_i;
      end else begin
        valid_q <= 1'b0;
        instr_q <= NOP_INSTR;
        pc4_q   <= 32'h0;
      end
    end
  end

  assign valid_o  = valid_q;
  assign instr_o  = instr_q;
  assign pc4_o    = pc4_q;
  assign opcode_o = instr_q[31:26];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, request FSM and a one-entry skid buffer that parks a
// returned word while decode stalls, feeding the IF/ID register.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic [5:0]  if_id_opcode
);

  localparam logic [31:0] RESET_PC_ALIGNED = wordAlign(RESET_PC);

  fetchState_t state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic [31:0] skidInstr_q, skidInstr_d;
  logic [31:0] skidPc4_q, skidPc4_d;
  logic        skidValid_q, skidValid_d;

  logic        ifIdHold, ifIdLoad, ifIdFlush;
  logic [31:0] ifIdInstr, ifIdPc4;
  logic [31:0] redirectTarget, pcNext4;

  assign redirectTarget = wordAlign(redirect_pc);
  assign pcNext4        = pcPlus4(pc_q);

  // Redirect is checked first in every state so it always wins over stall.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    skidInstr_d = skidInstr_q;
    skidPc4_d   = skidPc4_q;
    skidValid_d = skidValid_q;
    ifIdHold    = 1'b0;
    ifIdLoad    = 1'b0;
    ifIdFlush   = 1'b0;
    ifIdInstr   = imem_rdata;
    ifIdPc4     = pcNext4;
    case (state_q)
      FETCH: begin
        if (imem_ready) begin
          if (redirect) begin
            pc_d      = redirectTarget;
            ifIdFlush = 1'b1;
          end else if (stall) begin
            skidInstr_d = imem_rdata;
            skidPc4_d   = pcNext4;
            skidValid_d = 1'b1;
            pc_d        = pcNext4;
            ifIdHold    = 1'b1;
            state_d     = HOLD;
          end else begin
            ifIdLoad = 1'b1;
            pc_d     = pcNext4;
          end
        end else if (redirect) begin
          pc_d      = redirectTarget;
          ifIdFlush = 1'b1;
          state_d   = DISCARD;
        end else if (stall) begin
          ifIdHold = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          skidValid_d = 1'b0;
          pc_d        = redirectTarget;
          ifIdFlush   = 1'b1;
          state_d     = FETCH;
        end else if (stall) begin
          ifIdHold = 1'b1;
        end else begin
          ifIdLoad    = 1'b1;
          ifIdInstr   = skidInstr_q;
          ifIdPc4     = skidPc4_q;
          skidValid_d = 1'b0;
          state_d     = FETCH;
        end
      end
      DISCARD: begin
        ifIdFlush = 1'b1;
        if (redirect) pc_d = redirectTarget;
        if (imem_ready) state_d = FETCH;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // The request keeps its old address while a stale response is drained.
  assign req_d  = (state_d != HOLD);
  assign addr_d = (state_d == DISCARD) ? addr_q : pc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC_ALIGNED;
      addr_q      <= RESET_PC_ALIGNED;
      req_q       <= 1'b0;
      skidInstr_q <= NOP_INSTR;
      skidPc4_q   <= 32'h0;
      skidValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      req_q       <= req_d;
      skidInstr_q <= skidInstr_d;
      skidPc4_q   <= skidPc4_d;
      skidValid_q <= skidValid_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;

  if_id_reg uIfIdReg (
    .clk      (clk),
    .rst      (rst),
    .hold_i   (ifIdHold),
    .load_i   (ifIdLoad),
    .flush_i  (ifIdFlush),
    .instr_i  (ifIdInstr),
    .pc4_i    (ifIdPc4),
    .valid_o  (if_id_valid),
    .instr_o  (if_id_instr),
    .pc4_o    (if_id_pc4),
    .opcode_o (if_id_opcode)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random traffic, all
// checked every cycle against a transaction-level model of the fetch rules.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic [5:0]  if_id_opcode;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .if_id_valid  (if_id_valid),
    .if_id_instr  (if_id_instr),
    .if_id_pc4    (if_id_pc4),
    .if_id_opcode (if_id_opcode)
  );

  // Reference model: what fetch should look like from the outside.
  logic [31:0] mPc, mOutAddr, mInstr, mPc4, mSkidInstr, mSkidPc4;
  bit          mValid, mSkidFull, mDiscarding, mJustReset;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  task automatic modelReset();
    mPc = 32'h0; mOutAddr = 32'h0;
    mValid = 1'b0; mInstr = 32'h0; mPc4 = 32'h0;
    mSkidFull = 1'b0; mSkidInstr = 32'h0; mSkidPc4 = 32'h0;
    mDiscarding = 1'b0; mJustReset = 1'b1;
  endtask

  task automatic modelEmpty();
    mValid = 1'b0; mInstr = 32'h0; mPc4 = 32'h0;
  endtask

  task automatic modelStep(input bit st, input bit rd, input logic [31:0] rpc, input bit rdy, input logic [31:0] data);
    logic [31:0] tgt;
    tgt = rpc & 32'hFFFF_FFFC;
    mJustReset = 1'b0;
    if (mSkidFull) begin
      if (rd) begin
        mPc = tgt; modelEmpty(); mSkidFull = 1'b0;
      end else if (!st) begin
        mValid = 1'b1; mInstr = mSkidInstr; mPc4 = mSkidPc4; mSkidFull = 1'b0;
      end
    end else if (mDiscarding) begin
      if (rd) mPc = tgt;
      if (rd || !st) modelEmpty();
      if (rdy) mDiscarding = 1'b0;
    end else if (rdy) begin
      if (rd) begin
        mPc = tgt; modelEmpty();
      end else if (st) begin
        mSkidInstr = data; mSkidPc4 = mPc + 32'd4; mSkidFull = 1'b1; mPc = mPc + 32'd4;
      end else begin
        mValid = 1'b1; mInstr = data; mPc4 = mPc + 32'd4; mPc = mPc + 32'd4;
      end
    end else if (rd) begin
      mOutAddr = mPc; mPc = tgt; modelEmpty(); mDiscarding = 1'b1;
    end else if (!st) begin
      modelEmpty();
    end
  endtask

  task automatic checkAll();
    bit expReq;
    expReq = !mJustReset && !mSkidFull;
    checkOutput("imem_req", 32'(imem_req), 32'(expReq));
    if (expReq) checkOutput("imem_addr", imem_addr, mDiscarding ? mOutAddr : mPc);
    checkOutput("if_id_valid", 32'(if_id_valid), 32'(mValid));
    checkOutput("if_id_instr", if_id_instr, mInstr);
    checkOutput("if_id_pc4", if_id_pc4, mPc4);
    checkOutput("if_id_opcode", 32'(if_id_opcode), 32'(mInstr[31:26]));
  endtask

  task automatic applyStimulus(input bit st, input bit rd, input logic [31:0] rpc, input bit rdy, input logic [31:0] data);
    @(negedge clk);
    checkAll();
    stall = st; redirect = rd; redirect_pc = rpc; imem_ready = rdy; imem_rdata = data;
    @(posedge clk);
    modelStep(st, rd, rpc, rdy, data);
  endtask

  // Asserted mid-cycle so the asynchronous clear is visible before any edge.
  task automatic doReset();
    #2 rst = 1'b1;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; imem_ready = 1'b0; imem_rdata = 32'h0;
    #1;
    checkOutput("rst_req", 32'(imem_req), 32'h0);
    checkOutput("rst_addr", imem_addr, 32'h0);
    checkOutput("rst_valid", 32'(if_id_valid), 32'h0);
    checkOutput("rst_instr", if_id_instr, 32'h0);
    checkOutput("rst_pc4", if_id_pc4, 32'h0);
    checkOutput("rst_opcode", 32'(if_id_opcode), 32'h0);
    modelReset();
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  initial begin
    doReset();

    // Back-to-back fetches from reset.
    applyStimulus(0, 0, 32'h0, 1, 32'h8C01_0004);
    #1;
    checkOutput("seq_instr0", if_id_instr, 32'h8C01_0004);
    checkOutput("seq_pc4_0", if_id_pc4, 32'h4);
    checkOutput("seq_op0", 32'(if_id_opcode), 32'(6'b100011));
    checkOutput("seq_addr1", imem_addr, 32'h4);
    applyStimulus(0, 0, 32'h0, 1, 32'h2002_0005);
    #1;
    checkOutput("seq_instr1", if_id_instr, 32'h2002_0005);
    checkOutput("seq_pc4_1", if_id_pc4, 32'h8);
    checkOutput("seq_op1", 32'(if_id_opcode), 32'(6'b001000));

    // Stall while the word at 0x8 returns, then release.
    applyStimulus(1, 0, 32'h0, 1, 32'hAC03_0008);
    #1;
    checkOutput("hold_req", 32'(imem_req), 32'h0);
    checkOutput("hold_pc4", if_id_pc4, 32'h8);
    applyStimulus(1, 0, 32'h0, 0, 32'h0);
    applyStimulus(1, 0, 32'h0, 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 0, 32'h0);
    #1;
    checkOutput("unhold_pc4", if_id_pc4, 32'hC);
    checkOutput("unhold_instr", if_id_instr, 32'hAC03_0008);
    checkOutput("unhold_addr", imem_addr, 32'hC);
    applyStimulus(0, 0, 32'h0, 1, 32'h0022_1820);

    // Redirect while the request at 0x10 is still outstanding.
    applyStimulus(0, 1, 32'h40, 0, 32'h0);
    #1;
    checkOutput("disc_addr0", imem_addr, 32'h10);
    checkOutput("disc_valid0", 32'(if_id_valid), 32'h0);
    applyStimulus(0, 0, 32'h0, 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 32'hDEAD_BEEF);
    #1;
    checkOutput("disc_addr1", imem_addr, 32'h40);
    checkOutput("disc_valid1", 32'(if_id_valid), 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 32'h1000_FFFF);

    // Redirect and stall together, misaligned target.
    applyStimulus(1, 1, 32'h103, 1, 32'h1234_5678);
    #1;
    checkOutput("prio_instr", if_id_instr, 32'h0);
    checkOutput("prio_addr", imem_addr, 32'h100);

    // PC wrap at the top of the address space.
    applyStimulus(0, 1, 32'hFFFF_FFFC, 1, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 32'h0800_0000);
    #1;
    checkOutput("wrap_pc4", if_id_pc4, 32'h0);
    checkOutput("wrap_addr", imem_addr, 32'h0);

    // Reset during an outstanding request at 0x20; late ready taken as the reset-vector word.
    applyStimulus(0, 1, 32'h20, 1, 32'h0);
    applyStimulus(0, 0, 32'h0, 0, 32'h0);
    doReset();
    applyStimulus(0, 0, 32'h0, 1, 32'h3C01_ABCD);
    #1;
    checkOutput("late_instr", if_id_instr, 32'h3C01_ABCD);
    checkOutput("late_pc4", if_id_pc4, 32'h4);

    for (int i = 0; i < 800; i++) begin
      bit st, rd, rdy;
      logic [31:0] rpc;
      st  = ($urandom_range(0, 9) < 3);
      rd  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 9) < 6);
      rpc = $urandom;
      if ($urandom_range(0, 19) == 0) rpc = 32'hFFFF_FFFC;
      applyStimulus(st, rd, rpc, rdy, memWord(mDiscarding ? mOutAddr : mPc));
      if ($urandom_range(0, 199) == 0) doReset();
    end

    @(negedge clk);
    checkAll();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] SHALL be zero.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 stall  input  1  decode stage cannot accept; IF/ID SHALL hold.
REQ-005 redirect  input  1  taken branch or jump; flush and refetch.
REQ-006 redirect_pc  input  32  target address for redirect.
REQ-007 imem_req  output  1  instruction-memory request valid.
REQ-008 imem_addr  output  32  word address of the request.
REQ-009 imem_ready  input  1  memory returns imem_rdata this cycle; completes the request.
REQ-010 imem_rdata  input  32  instruction word, valid only when imem_ready=1.
REQ-011 if_id_valid  output  1  IF/ID holds a real instruction.
REQ-012 if_id_instr  output  32  registered instruction.
REQ-013 if_id_pc4  output  32  registered fetch address + 4.
REQ-014 if_id_opcode  output  6  if_id_instr[31:26]; feeds the control unit's opcode input.

Function
REQ-015 States SHALL be FETCH, HOLD, DISCARD; reset state FETCH.
REQ-016 FETCH: imem_req=1, imem_addr=pc; imem_addr SHALL stay stable until imem_ready=1.
REQ-017 FETCH, imem_ready=1, stall=0, redirect=0: IF/ID <= {1, imem_rdata, pc+4}; pc <= pc+4; stay FETCH. Back-to-back fetches SHALL sustain one instruction per ready cycle.
REQ-018 FETCH, imem_ready=1, stall=1, redirect=0: rdata and pc+4 captured in a one-entry skid buffer; pc <= pc+4; IF/ID unchanged; go HOLD.
REQ-019 HOLD: imem_req=0; stall=1 keeps IF/ID and buffer; stall=0 moves buffer into IF/ID (valid=1), go FETCH.
REQ-020 FETCH, imem_ready=0, redirect=1: pc <= redirect_pc; IF/ID flushed; go DISCARD; imem_req and imem_addr unchanged until ready.
REQ-021 DISCARD: imem_req=1 on the old address; on imem_ready=1 the data SHALL be dropped, go FETCH at the new pc; further redirects in DISCARD only update pc.
REQ-022 FETCH, imem_ready=1, redirect=1: returned data dropped; pc <= redirect_pc; IF/ID flushed; stay FETCH.
REQ-023 HOLD, redirect=1: buffer discarded; pc <= redirect_pc; IF/ID flushed; go FETCH.
REQ-024 Flush: if_id_valid=0, if_id_instr=32'h0000_0000 (NOP), if_id_pc4=0.
REQ-025 redirect SHALL take priority over stall whenever both are asserted.
REQ-026 stall=1 with no new data: IF/ID SHALL hold all fields unchanged.
REQ-027 stall=0, no capture in that cycle: IF/ID SHALL load a bubble (valid=0, NOP).
REQ-028 redirect_pc[1:0] SHALL be ignored (forced to 0).
REQ-029 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).

Reset
REQ-030 On rst=1, asynchronously: pc=RESET_PC, state=FETCH, buffer empty, if_id_valid=0, if_id_instr=0, if_id_pc4=0, if_id_opcode=0.
REQ-031 imem_req SHALL be 0 while rst=1 and SHALL assert on the first clk edge after release, with imem_addr=RESET_PC.
REQ-032 Reset mid-request SHALL abandon the outstanding request; a late imem_ready after release SHALL be consumed as the RESET_PC response.

Structure
REQ-033 Shared package mips_pkg: RESET_PC default, NOP_INSTR, opcode constants (R-type, lw, sw, beq, bne, j, jal, immediates), fetch-state encoding.
REQ-034 One sub-module, if_id_reg: IF/ID register with hold/load/flush inputs; the FSM, PC and skid buffer stay in fetch_stage.

Verification
REQ-035 Reset release, imem_ready=1 every cycle, rdata 0x8C010004, 0x20020005 -> imem_addr 0x0, 0x4; IF/ID (0x8C010004, pc4 0x4), then (0x20020005, 0x8); opcode 6'b100011 then 6'b001000.
REQ-036 Capture at addr 0x8 with stall=1 for 3 cycles -> state HOLD, imem_req=0, IF/ID unchanged; stall drop -> IF/ID pc4=0xC next edge, fetch resumes at 0xC.
REQ-037 Request at 0x10, imem_ready low 2 cycles, redirect=1 to 0x40 in the first -> imem_addr stays 0x10 until ready, data dropped, next imem_addr 0x40, if_id_valid=0 meanwhile.
REQ-038 stall=1 and redirect=1 same cycle, redirect_pc=0x103 -> IF/ID flushed (instr 0, valid 0), next imem_addr 0x100.
REQ-039 pc=0xFFFF_FFFC, ready -> if_id_pc4=0x0, next imem_addr 0x0.
REQ-040 rst pulsed mid-request at 0x20 -> outputs reset immediately; after release imem_addr=0x0.
